// File: rtl/mmio_gpio_if.sv
// CPU data-bus slave port for mmio_gpio: decoder strobes, address, data.
interface mmio_gpio_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wtData;
    logic [31:0] rdData;

    modport master (
        output ce,
        output we,
        output addr,
        output wtData,
        input  rdData
    );

    modport slave (
        input  ce,
        input  we,
        input  addr,
        input  wtData,
        output rdData
    );
endinterface

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: synced switches, debounced buttons with latched
// rising-edge status and maskable interrupt, LED register and a scanned
// hex seven-segment display.
module mmio_gpio #(
    parameter logic [31:0] BASE     = 32'hFFFF_F000,
    parameter int unsigned SW_W     = 2,
    parameter int unsigned BTN_W    = 8,
    parameter int unsigned LED_W    = 16,
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned DEB_CNT  = 1000000,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    mmio_gpio_if.slave        bus,
    input  logic [SW_W-1:0]   sw,
    input  logic [BTN_W-1:0]  btn,
    output logic [LED_W-1:0]  led,
    output logic [DIGITS-1:0] seg_an,
    output logic [7:0]        seg_cat,
    output logic              irq
);

    localparam int unsigned CNT_W = $clog2(DEB_CNT);
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Hex digit to active-low cathodes {dp,g,f,e,d,c,b,a}, dp off.
    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    logic [SW_W-1:0]             sw_s1_q, sw_s2_q;
    logic [BTN_W-1:0]            btn_s1_q, btn_s2_q;
    logic [BTN_W-1:0]            stable_q, stable_d;
    logic [BTN_W-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [BTN_W-1:0]            edge_q, edge_d;
    logic [BTN_W-1:0]            mask_q, mask_d;
    logic [LED_W-1:0]            led_q, led_d;
    logic [31:0]                 seg_q, seg_d;
    logic                        irq_q, irq_d;
    logic [PRE_W-1:0]            presc_q, presc_d;
    logic [DIG_W-1:0]            dig_q, dig_d;
    logic [DIGITS-1:0]           an_q, an_d;
    logic [7:0]                  cat_q, cat_d;

    logic        hit, wr_en, rd_en;
    logic [2:0]  off;
    logic [31:0] rd_data;
    logic [3:0]  nib;
    logic [BTN_W-1:0] edge_set, edge_clr;
    logic        unused_addr;

    assign hit         = (bus.addr[31:5] == BASE[31:5]);
    assign wr_en       = bus.ce & bus.we & hit;
    assign rd_en       = bus.ce & ~bus.we & hit;
    assign off         = bus.addr[4:2];
    assign unused_addr = ^bus.addr[1:0];

    // Read mux: side-effect free, zero outside a hitting read.
    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (off)
                3'd0: rd_data[SW_W-1:0]  = sw_s2_q;
                3'd1: rd_data[BTN_W-1:0] = stable_q;
                3'd2: rd_data[BTN_W-1:0] = edge_q;
                3'd3: rd_data            = seg_q;
                3'd4: rd_data[LED_W-1:0] = led_q;
                3'd5: rd_data[BTN_W-1:0] = mask_q;
                default: rd_data = '0;
            endcase
        end
    end
    assign bus.rdData = rd_data;

    // Bus-writable registers; EDGE write is a W1C clear mask.
    always_comb begin
        led_d    = led_q;
        seg_d    = seg_q;
        mask_d   = mask_q;
        edge_clr = '0;
        if (wr_en) begin
            case (off)
                3'd2: edge_clr = bus.wtData[BTN_W-1:0];
                3'd3: seg_d    = bus.wtData;
                3'd4: led_d    = bus.wtData[LED_W-1:0];
                3'd5: mask_d   = bus.wtData[BTN_W-1:0];
                default: ;
            endcase
        end
    end

    // Per-channel debounce: accept the synced level after DEB_CNT mismatched cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int unsigned i = 0; i < BTN_W; i++) begin
            if (btn_s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEB_CNT - 1))
                    stable_d[i] = btn_s2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge capture (set beats a same-cycle clear) and registered interrupt.
    always_comb begin
        edge_set = stable_d & ~stable_q;
        edge_d   = (edge_q & ~edge_clr) | edge_set;
        irq_d    = |(edge_q & mask_q);
    end

    // Display scan: prescaler, digit index, and next an/cat from current index.
    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        dig_d   = dig_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            dig_d   = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
        end
        nib   = 4'(seg_q >> {dig_q, 2'b00});
        an_d  = ~(DIGITS'(1) << dig_q);
        cat_d = hex7(nib);
    end

    // State update with synchronous reset taking priority over bus writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            led_q    <= '0;
            seg_q    <= '0;
            irq_q    <= 1'b0;
            presc_q  <= '0;
            dig_q    <= '0;
            an_q     <= '1;
            cat_q    <= 8'hFF;
        end else begin
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            led_q    <= led_d;
            seg_q    <= seg_d;
            irq_q    <= irq_d;
            presc_q  <= presc_d;
            dig_q    <= dig_d;
            an_q     <= an_d;
            cat_q    <= cat_d;
        end
    end

    assign led     = led_q;
    assign irq     = irq_q;
    assign seg_an  = an_q;
    assign seg_cat = cat_q;

endmodule

// File: doc/mmio_gpio.md
# mmio_gpio

Parametrised memory-mapped GPIO block on the CPU data bus. It exposes switches, debounced push-buttons with latched rising-edge status, a maskable interrupt, an LED register and a multiplexed hex seven-segment display. It sits beside data RAM behind the same `ce`/`we`/`addr` decode and replaces the single-shot switch/button/segment/LED register file. It adds debouncing, edge capture, interrupts and display scanning.

## Interface
- `BASE`, 32'hFFFF_F000: byte base address; block responds when `addr[31:5] == BASE[31:5]`.
- `SW_W`, 2: switch width (1..32).
- `BTN_W`, 8: button channel count (1..32).
- `LED_W`, 16: LED width (1..32).
- `DIGITS`, 8: seven-segment digits (1..8), nibble i of SEG shown on digit i.
- `DEB_CNT`, 1000000: stable cycles required to accept a button change (≥2).
- `SCAN_DIV`, 100000: clock cycles per digit in the display scan (≥1).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ce` in 1: chip enable from the bus decoder.
- `we` in 1: 1 = write, 0 = read.
- `addr` in 32: byte address; word offset is `addr[4:2]`.
- `wtData` in 32: write data.
- `rdData` out 32: read data, combinational.
- `sw` in SW_W: raw switches (asynchronous).
- `btn` in BTN_W: raw buttons, active-high (asynchronous).
- `led` out LED_W: LED register.
- `seg_an` out DIGITS: digit enables, active-low, one-hot-low.
- `seg_cat` out 8: cathodes {dp,g,f,e,d,c,b,a}, active-low; dp always off (bit 7 = 1).
- `irq` out 1: registered, level-high interrupt.

## Operation
Register map (offset, access):
- 0x00 SW (R): 2-flop-synchronised `sw`, zero-extended.
- 0x04 BTN (R): debounced button levels.
- 0x08 EDGE (R/W1C): pending rising edges, one bit per channel; writing 1 clears, writing 0 has no effect.
- 0x0C SEG (R/W): 32-bit display value.
- 0x10 LED (R/W): `wtData[LED_W-1:0]`.
- 0x14 MASK (R/W): `wtData[BTN_W-1:0]`.
- 0x18, 0x1C: reads return 0; writes are ignored.

Reads:
- `rdData` is 0 when `ce`=0, `we`=1, or the address misses BASE.
- Narrow fields are zero-extended.
- Reads have no side effects.

Writes happen on the clock edge when `ce`=1, `we`=1 and the address hits BASE.

Button debounce, per channel:
- Raw input passes a 2-flop synchroniser.
- A counter runs while the synced value differs from the stable value and clears when they match.
- When the counter reaches DEB_CNT-1, the stable value takes the synced value and the counter clears.
- A 0→1 transition of the stable value sets the channel's EDGE bit.

EDGE W1C collision: if a set and a W1C clear hit the same bit in the same cycle, the set wins.

`irq` is registered as `|(EDGE & MASK)` and updates one cycle after EDGE or MASK changes.

Display scan:
- A prescaler counts 0..SCAN_DIV-1.
- When it wraps, the digit index advances modulo DIGITS (DIGITS-1 → 0).
- `seg_an` and `seg_cat` are registered from the current index and its SEG nibble.
- The hex decode covers 0–F: `0`=0xC0, `1`=0xF9, `8`=0x80, `F`=0x8E.

## Timing
Reset values, with `rst` held high:
- `led`, SEG, MASK, EDGE, stable levels, counters, prescaler and digit index are all 0.
- `irq`=0.
- `seg_an` is all ones; `seg_cat`=0xFF.
- The first cycle after reset drives digit 0.

Reset mid-operation takes priority over any bus write in the same cycle and abandons debounce counts in progress.

Latency:
- Write → `led` visible, or SEG readback: 1 cycle.
- `btn` edge → BTN/EDGE set: 2 (sync) + DEB_CNT cycles.
- EDGE set → `irq`: +1 cycle.
- SEG write → cathodes change: at the next scan register update, at most 1 cycle later.

A bounce shorter than DEB_CNT cycles never changes BTN.

## Test plan
Run all scenarios with `DEB_CNT`=4, `SCAN_DIV`=3, `DIGITS`=4, `BTN_W`=4.
- Reset: assert `rst` 2 cycles → `led`=0, `irq`=0, `seg_an`=4'b1111, `seg_cat`=0xFF; all reads return 0x0.
- LED/SEG: write 0xFFFF_A5A5 to 0x10, then 0x0000_1234 to 0x0C → `led`=16'hA5A5, read 0x0C returns 0x1234. Scan then shows `seg_an` 1110/1101/1011/0111, 3 cycles each, with cathodes 0x99('4'), 0xB0('3'), 0xA4('2'), 0xF9('1'), and wraps back to 1110.
- Debounce: `btn[1]` pulses high 3 cycles → BTN stays 0. `btn[1]` held high → BTN reads 0x2 six cycles after the rise and EDGE=0x2; `irq` stays 0 because MASK=0.
- IRQ/W1C: write MASK=0x2 → `irq`=1 one cycle later. Write 0x2 to 0x08 → EDGE=0, then `irq`=0 the following cycle. Writing 0x0 to 0x08 leaves EDGE unchanged.
- Collision: schedule a `btn[0]` rising edge so EDGE[0] sets in the same cycle as a W1C write of 0x1 → EDGE reads 0x1 afterwards.
- Decode/miss: `ce`=0, or addr=BASE+0x20, or offset 0x18, with a write of 0xFFFF_FFFF → no register changes and the read returns 0. SW read with `sw`=2'b10 returns 0x2 after 2 cycles.
